// File: rtl/poly_tile_issuer.sv
// Tile issuer: streams every (A tile, B tile) pair of two coefficient stores to a multiplier.
// Optional watchdog on the multiplier response enabled by `define POLY_ISSUE_WATCHDOG_EN.
module poly_tile_issuer #(
   parameter int DATA_WIDTH   = 64,
   parameter int POLY_A_WIDTH = 64,
   parameter int POLY_B_WIDTH = 64,
   parameter int TILE_WIDTH   = 8,
   localparam int ADDR_W  = $clog2(POLY_A_WIDTH > POLY_B_WIDTH ? POLY_A_WIDTH : POLY_B_WIDTH),
   localparam int AW_A    = $clog2(POLY_A_WIDTH),
   localparam int AW_B    = $clog2(POLY_B_WIDTH),
   localparam int A_TILES = POLY_A_WIDTH / TILE_WIDTH,
   localparam int B_TILES = POLY_B_WIDTH / TILE_WIDTH,
   localparam int AI_W    = (A_TILES > 1) ? $clog2(A_TILES) : 1,
   localparam int BI_W    = (B_TILES > 1) ? $clog2(B_TILES) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic                             wr_sel,
   input  logic [ADDR_W-1:0]                wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             start,
   output logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_a,
   output logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_b,
   output logic                             inputs_ready_signal,
   input  logic                             outputs_ready_signal,
   output logic [AI_W-1:0]                  tile_a_idx,
   output logic [BI_W-1:0]                  tile_b_idx,
   output logic                             busy,
   output logic                             done,
`ifdef POLY_ISSUE_WATCHDOG_EN
   output logic                             timeout_err,
`endif
   output logic [1:0]                       state_dbg
);

   // Handshake: inputs_ready_signal is high for the single ISSUE cycle; tile_a/tile_b are
   // held until outputs_ready_signal is sampled high in WAIT, which completes the pair.
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t state, state_nx;
   logic [1:0] rst_sync;
   logic rst_n_int;
   logic [DATA_WIDTH-1:0] mem_a [POLY_A_WIDTH];
   logic [DATA_WIDTH-1:0] mem_b [POLY_B_WIDTH];
   logic [AW_A-1:0] ra;
   logic [AW_B-1:0] rb;
   logic a_last, b_last, pair_done, accept;

   // Assert asynchronously, release two edges later in step with clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_int = rst_sync[1];

   assign accept    = (state == IDLE) && start;
   assign pair_done = (state == WAIT) && outputs_ready_signal;
   assign a_last    = (tile_a_idx == AI_W'(A_TILES - 1));
   assign b_last    = (tile_b_idx == BI_W'(B_TILES - 1));

   // Stores are never reset so coefficients survive a reset.
   always_ff @(posedge clk) begin
      if (rst_n_int && wr_en && state == IDLE) begin
         if (!wr_sel && {1'b0, wr_addr} < (ADDR_W+1)'(POLY_A_WIDTH))
            mem_a[wr_addr[AW_A-1:0]] <= wr_data;
         if (wr_sel && {1'b0, wr_addr} < (ADDR_W+1)'(POLY_B_WIDTH))
            mem_b[wr_addr[AW_B-1:0]] <= wr_data;
      end
   end

`ifdef POLY_ISSUE_WATCHDOG_EN
   logic [7:0] wd_cnt;
   logic wd_fire;
   assign wd_fire = (state == WAIT) && !outputs_ready_signal && (wd_cnt == 8'd254);

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         wd_cnt <= (state == WAIT) ? wd_cnt + 8'd1 : 8'd0;
         if (accept)       timeout_err <= 1'b0;
         else if (wd_fire) timeout_err <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = ISSUE;
         ISSUE: state_nx = WAIT;
         WAIT: begin
            if (outputs_ready_signal) state_nx = (a_last && b_last) ? DONE : ISSUE;
`ifdef POLY_ISSUE_WATCHDOG_EN
            else if (wd_fire)         state_nx = IDLE;
`endif
         end
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // B index is the inner loop; after the last pair both wrap back to zero.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         tile_a_idx <= '0;
         tile_b_idx <= '0;
      end else if (accept) begin
         tile_a_idx <= '0;
         tile_b_idx <= '0;
      end else if (pair_done) begin
         if (b_last) begin
            tile_b_idx <= '0;
            tile_a_idx <= a_last ? '0 : tile_a_idx + AI_W'(1);
         end else begin
            tile_b_idx <= tile_b_idx + BI_W'(1);
         end
      end
   end

   // Tiles are read straight from the stores, so a write accepted with start shows up at once.
   always_comb begin
      tile_a = '0;
      tile_b = '0;
      ra     = '0;
      rb     = '0;
      if (state == ISSUE || state == WAIT) begin
         for (int k = 0; k < TILE_WIDTH; k++) begin
            ra = AW_A'(int'(tile_a_idx) * TILE_WIDTH + k);
            rb = AW_B'(int'(tile_b_idx) * TILE_WIDTH + k);
            tile_a[DATA_WIDTH*k +: DATA_WIDTH] = mem_a[ra];
            tile_b[DATA_WIDTH*k +: DATA_WIDTH] = mem_b[rb];
         end
      end
   end

   assign inputs_ready_signal = (state == ISSUE);
   assign busy                = (state != IDLE);
   assign done                = (state == DONE);
   assign state_dbg           = state;

endmodule

// File: tb/tb_poly_tile_issuer.sv
// Self-checking bench for poly_tile_issuer: directed steps, tile-pair scoreboard.
// Watchdog steps are included when POLY_ISSUE_WATCHDOG_EN is defined.
module tb_poly_tile_issuer;

   localparam int DW = 64;
   localparam int TW = 8;
   localparam int TB = TW * DW;
   localparam int W  = 6 + 2 * TB;

   logic          clk, rst, wr_en, wr_sel, start, outputs_ready_signal;
   logic [5:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [TB-1:0] tile_a, tile_b;
   logic          inputs_ready_signal, busy, done;
   logic [2:0]    tile_a_idx, tile_b_idx;
   logic [1:0]    state_dbg;
`ifdef POLY_ISSUE_WATCHDOG_EN
   logic          timeout_err;
`endif

   poly_tile_issuer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .tile_a(tile_a), .tile_b(tile_b),
      .inputs_ready_signal(inputs_ready_signal), .outputs_ready_signal(outputs_ready_signal),
      .tile_a_idx(tile_a_idx), .tile_b_idx(tile_b_idx), .busy(busy), .done(done),
`ifdef POLY_ISSUE_WATCHDOG_EN
      .timeout_err(timeout_err),
`endif
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "global timeout");
   end

   // scoreboard state
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  mon_e;
   logic [DW-1:0] model_a[64];
   logic [DW-1:0] model_b[64];
   int n_pass = 0, n_total = 0;
   int pulse_cnt = 0, done_cnt = 0, exp_pulses = 0, exp_done = 0;
   logic prev_irs = 1'b0;

   task automatic check(input string tag, input logic [TB-1:0] obs, input logic [TB-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h required %0h", tag, obs, exp);
   endtask

   function automatic logic [TB-1:0] mk_tile(input bit sel, input int t);
      logic [TB-1:0] r;
      r = '0;
      for (int k = 0; k < TW; k++)
         r[DW*k +: DW] = sel ? model_b[t*TW+k] : model_a[t*TW+k];
      return r;
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input bit sel, input int addr, input logic [DW-1:0] data, input bit accepted);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = data;
      tick();
      wr_en = 1'b0;
      if (accepted) begin
         if (sel) model_b[addr] = data;
         else     model_a[addr] = data;
      end
   endtask

   task automatic push_pair(input int a, input int b);
      exp_q.push_back({3'(a), 3'(b), mk_tile(1'b0, a), mk_tile(1'b1, b)});
      exp_pulses++;
   endtask

   task automatic push_run();
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            push_pair(a, b);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Respond to n tile pulses, raising outputs_ready_signal d cycles after each pulse.
   task automatic serve(input int n, input int d);
      int budget;
      for (int i = 0; i < n; i++) begin
         budget = 0;
         while (!inputs_ready_signal && budget < 50) begin
            tick();
            budget++;
         end
         if (!inputs_ready_signal) begin
            check("pulse_wait", 0, 1);
            return;
         end
         repeat (d) tick();
         outputs_ready_signal = 1'b1;
         tick();
         outputs_ready_signal = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while (busy && budget < 20) begin
         tick();
         budget++;
      end
      check("idle_wait", busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_irs"}, inputs_ready_signal, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_idx"}, {tile_a_idx, tile_b_idx}, 0);
      check({tag, "_tile_a"}, tile_a, 0);
      check({tag, "_tile_b"}, tile_b, 0);
`ifdef POLY_ISSUE_WATCHDOG_EN
      check({tag, "_timeout"}, timeout_err, 0);
`endif
   endtask

   // monitor: pop and compare on every tile pulse
   always @(negedge clk) begin
      if (inputs_ready_signal) begin
         pulse_cnt++;
         check("pulse_width", prev_irs, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("idx_pair", {tile_a_idx, tile_b_idx}, mon_e[W-1 -: 6]);
            check("tile_a", tile_a, mon_e[2*TB-1 -: TB]);
            check("tile_b", tile_b, mon_e[TB-1:0]);
         end
      end
      if (done) done_cnt++;
      prev_irs = inputs_ready_signal;
   end

   initial begin
      logic [TB-1:0] first_a, ones_b;
      int n;
      rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; outputs_ready_signal = 1'b0;
      for (int k = 0; k < 64; k++) begin
         model_a[k] = '0;
         model_b[k] = '0;
      end
      repeat (3) tick();
      check_reset_outputs("por");
      rst = 1'b1;
      tick();
      check("release_busy", busy, 0);
      check("release_irs", inputs_ready_signal, 0);
      repeat (2) tick();

      // write-and-issue
      for (int k = 0; k < 64; k++) begin
         write_coef(1'b0, k, DW'(k + 1), 1'b1);
         write_coef(1'b1, k, DW'(1), 1'b1);
      end
      for (int k = 0; k < TW; k++) begin
         first_a[DW*k +: DW] = DW'(k + 1);
         ones_b[DW*k +: DW]  = DW'(1);
      end
      push_run();
      pulse_start();
      check("first_tile_a", tile_a, first_a);
      check("first_tile_b", tile_b, ones_b);
      check("busy_run", busy, 1);
      serve(64, 3);
      check("done_pulse", done, 1);
      exp_done++;
      wait_idle();
      check("done_count_1", done_cnt, exp_done);
      check("queue_empty_1", exp_q.size(), 0);

      // back-pressure: outputs_ready_signal held through ISSUE is ignored
      push_run();
      pulse_start();
      outputs_ready_signal = 1'b1;
      tick();
      check("bp_idx_hold", {tile_a_idx, tile_b_idx}, 6'd0);
      check("bp_no_pulse", inputs_ready_signal, 0);
      tick();
      outputs_ready_signal = 1'b0;
      check("bp_advance", {tile_a_idx, tile_b_idx}, 6'd1);
      serve(63, $urandom_range(1, 4));
      exp_done++;
      wait_idle();

      // writes while busy are dropped
      push_run();
      pulse_start();
      fork
         serve(64, 3);
         begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = DW'(64'hFFFF);
            tick();
            tick();
            wr_en = 1'b0;
         end
      join
      exp_done++;
      wait_idle();
      push_run();
      pulse_start();
      check("busy_write_dropped", tile_a[DW-1:0], DW'(1));
      serve(64, 2);
      exp_done++;
      wait_idle();

      // write and start in the same IDLE cycle
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd1; wr_data = DW'(64'hABCD);
      model_a[1] = DW'(64'hABCD);
      push_run();
      start = 1'b1;
      tick();
      start = 1'b0; wr_en = 1'b0;
      check("same_cycle_write", tile_a[2*DW-1 -: DW], DW'(64'hABCD));
      serve(64, 1);
      exp_done++;
      wait_idle();

      // reset mid-transfer after pair (3,5)
      push_run();
      pulse_start();
      serve(30, 2);
      check("pre_reset_idx", {tile_a_idx, tile_b_idx}, {3'd3, 3'd6});
      rst = 1'b0;
      exp_pulses -= exp_q.size();
      exp_q.delete();
      #1;
      check_reset_outputs("mid_rst");
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check("mid_release_busy", busy, 0);
      repeat (2) tick();
      push_run();
      pulse_start();
      check("restart_idx", {tile_a_idx, tile_b_idx}, 6'd0);
      serve(64, 2);
      exp_done++;
      wait_idle();
      check("done_count_2", done_cnt, exp_done);

`ifdef POLY_ISSUE_WATCHDOG_EN
      // watchdog: no response at all
      push_pair(0, 0);
      pulse_start();
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      check("wd_cycles", n, 256);
      check("wd_flag", timeout_err, 1);
      check("wd_busy", busy, 0);
      tick();
      check("wd_flag_sticky", timeout_err, 1);
      check("wd_no_done", done_cnt, exp_done);
      push_run();
      pulse_start();
      check("wd_flag_cleared", timeout_err, 0);
      serve(64, 1);
      exp_done++;
      wait_idle();
`else
      n = 0;
`endif

      repeat (2) tick();
      check("final_queue_empty", exp_q.size(), 0);
      check("final_pulses", pulse_cnt, exp_pulses);
      check("final_done", done_cnt, exp_done);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/poly_tile_issuer.md
POLY_TILE_ISSUER -- requirements
Module: poly_tile_issuer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, coefficient width in bits.
REQ-002 SHALL have parameter POLY_A_WIDTH, default 64, coefficient count of polynomial A.
REQ-003 SHALL have parameter POLY_B_WIDTH, default 64, coefficient count of polynomial B.
REQ-004 SHALL have parameter TILE_WIDTH, default 8, coefficients per tile; it must divide POLY_A_WIDTH and POLY_B_WIDTH.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have the following ports:
- wr_en  in  1  coefficient write strobe.
- wr_sel  in  1  write target: 0 = A, 1 = B.
- wr_addr  in  $clog2(max(POLY_A_WIDTH,POLY_B_WIDTH))  coefficient index.
- wr_data  in  DATA_WIDTH  coefficient value.
- start  in  1  begin issuing tiles.
- tile_a  out  TILE_WIDTH*DATA_WIDTH  A tile to multiplier.
- tile_b  out  TILE_WIDTH*DATA_WIDTH  B tile to multiplier.
- inputs_ready_signal  out  1  tile-valid pulse to multiplier.
- outputs_ready_signal  in  1  multiplier finished current tile pair.
- tile_a_idx  out  $clog2(POLY_A_WIDTH/TILE_WIDTH)  current A tile index.
- tile_b_idx  out  $clog2(POLY_B_WIDTH/TILE_WIDTH)  current B tile index.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky watchdog flag; exists only under the REQ-024 macro.

Function
REQ-007 SHALL hold two coefficient stores: A[POLY_A_WIDTH] and B[POLY_B_WIDTH].
REQ-008 SHALL write wr_data to A[wr_addr] or B[wr_addr] on a clk edge with wr_en=1, only in IDLE; writes in any other state, or with wr_addr out of range, are dropped.
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-010 SHALL transition as follows:
- IDLE→ISSUE on start=1, clearing tile_a_idx and tile_b_idx to 0.
- ISSUE→WAIT unconditionally after one cycle.
- WAIT→ISSUE on outputs_ready_signal=1 when tiles remain.
- WAIT→DONE on outputs_ready_signal=1 for the last pair.
- DONE→IDLE after one cycle.
REQ-011 SHALL assert inputs_ready_signal for exactly the single ISSUE cycle, i.e., on the cycle after start is sampled or after outputs_ready_signal is sampled.
REQ-012 SHALL drive tile_a slice [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k] = A[tile_a_idx*TILE_WIDTH+k], with tile_b formed the same way from B; both SHALL be stable from ISSUE through the end of WAIT.
REQ-013 SHALL order pairs with tile_a_idx outer and tile_b_idx inner; on completion of a pair, tile_b_idx increments, and on tile_b_idx wrap tile_a_idx increments.
REQ-014 SHALL issue exactly (POLY_A_WIDTH/TILE_WIDTH)*(POLY_B_WIDTH/TILE_WIDTH) pairs per start; with defaults this is 64.
REQ-015 SHALL ignore start outside IDLE, and ignore outputs_ready_signal outside WAIT, including when it arrives in the ISSUE cycle.
REQ-016 SHALL assert done for one cycle in DONE; busy=1 in ISSUE, WAIT and DONE.
REQ-017 SHALL act on start and wr_en arriving in the same IDLE cycle: the write is performed and issuing begins, and the first tile reflects the written value.

Reset
REQ-018 SHALL, on rst=0 at any time including mid-transfer, immediately enter IDLE and force inputs_ready_signal=0, busy=0, done=0, tile_a_idx=0, tile_b_idx=0, tile_a=0, tile_b=0, timeout_err=0.
REQ-019 SHALL retain coefficient store contents across reset; they are not cleared.
REQ-020 SHALL release reset synchronously to clk, with no output activity in the first cycle after release.

Configuration
REQ-021 SHALL, under POLY_ISSUE_WATCHDOG_EN, count WAIT cycles per pair with an 8-bit counter.
REQ-022 SHALL, under POLY_ISSUE_WATCHDOG_EN, on reaching 255 without outputs_ready_signal, set timeout_err, go to IDLE with busy=0, and not pulse done.
REQ-023 SHALL clear timeout_err only on reset or on the next accepted start.
REQ-024 SHALL, without POLY_ISSUE_WATCHDOG_EN, omit the counter and the timeout_err port, and wait indefinitely in WAIT.

Verification
REQ-025 SHALL cover write-and-issue: write A[k]=k+1 and B[k]=1 for all k, start, respond with outputs_ready_signal 3 cycles after each pulse → 64 single-cycle inputs_ready_signal pulses; the first pulse carries tile_a={8,7,...,1} (MSB slice first) and tile_b all ones; idx sequence (0,0),(0,1)...(7,7); done pulses once.
REQ-026 SHALL cover the back-pressure window: outputs_ready_signal held 1 during ISSUE → ignored; the idx pair does not advance until outputs_ready_signal is seen in WAIT.
REQ-027 SHALL cover busy-period writes: start, then wr_en to A[0]=0xFFFF while busy → dropped; the next run issues the old A[0].
REQ-028 SHALL cover reset mid-transfer: rst=0 after pair (3,5) → outputs at reset values in the same cycle; after release, start reissues from (0,0) with the prior coefficients.
REQ-029 SHALL cover the watchdog under POLY_ISSUE_WATCHDOG_EN: start with no outputs_ready_signal → timeout_err=1 after 255 WAIT cycles, busy=0, no done; the next start clears timeout_err.
